// File: rtl/pu_or1k_store_buffer_fwd.sv
// Register-based store buffer: in-order drain, tail-word coalescing and a
// parallel store-to-load forwarding lookup across all live entries.
module pu_or1k_store_buffer_fwd #(
    parameter int DEPTH_WIDTH          = 4,
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int ENABLE_COALESCE      = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   pc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   dat_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_i,
    input  logic                              atomic_i,
    input  logic                              write_i,
    output logic [OPTION_OPERAND_WIDTH-1:0]   pc_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dat_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_o,
    output logic                              atomic_o,
    input  logic                              read_i,
    output logic                              full_o,
    output logic                              empty_o,
    output logic [DEPTH_WIDTH:0]              count_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   lookup_adr_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] lookup_bsel_i,
    output logic                              lookup_hit_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   lookup_dat_o,
    output logic                              lookup_conflict_o
);

    localparam int OW    = OPTION_OPERAND_WIDTH;
    localparam int BW    = OW / 8;
    localparam int DEPTH = 1 << DEPTH_WIDTH;

    localparam logic [DEPTH_WIDTH:0]   PTR_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};
    localparam logic [DEPTH_WIDTH-1:0] IDX_ONE = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};

    logic [DEPTH_WIDTH:0] wptr_q, wptr_d;
    logic [DEPTH_WIDTH:0] rptr_q, rptr_d;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] atomic_q, atomic_d;
    logic [OW-1:0]    pc_q   [DEPTH];
    logic [OW-1:0]    pc_d   [DEPTH];
    logic [OW-1:0]    adr_q  [DEPTH];
    logic [OW-1:0]    adr_d  [DEPTH];
    logic [OW-1:0]    dat_q  [DEPTH];
    logic [OW-1:0]    dat_d  [DEPTH];
    logic [BW-1:0]    bsel_q [DEPTH];
    logic [BW-1:0]    bsel_d [DEPTH];

    logic [DEPTH_WIDTH-1:0] widx;
    logic [DEPTH_WIDTH-1:0] ridx;
    logic [DEPTH_WIDTH-1:0] tidx;

    logic full;
    logic empty;
    logic [DEPTH_WIDTH:0] count;
    logic pop;
    logic push;
    logic coalesce;
    logic tail_popping;

    assign widx  = wptr_q[DEPTH_WIDTH-1:0];
    assign ridx  = rptr_q[DEPTH_WIDTH-1:0];
    assign tidx  = widx - IDX_ONE;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[DEPTH_WIDTH] != rptr_q[DEPTH_WIDTH]) && (widx == ridx);
    assign count = wptr_q - rptr_q;

    // With a single entry, head and tail are the same slot; merging into a
    // slot that is leaving this cycle would lose the store.
    assign tail_popping = (count == PTR_ONE) && read_i;

    assign coalesce = (ENABLE_COALESCE != 0) && write_i && !atomic_i && !empty
                      && !atomic_q[tidx]
                      && (adr_q[tidx][OW-1:2] == adr_i[OW-1:2])
                      && !tail_popping;

    assign pop  = read_i && !empty;
    assign push = write_i && !coalesce && (!full || read_i);

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        valid_d  = valid_q;
        atomic_d = atomic_q;
        pc_d     = pc_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        bsel_d   = bsel_q;

        if (pop) begin
            valid_d[ridx] = 1'b0;
            rptr_d        = rptr_q + PTR_ONE;
        end

        if (coalesce) begin
            for (int b = 0; b < BW; b++) begin
                if (bsel_i[b]) begin
                    dat_d[tidx][8*b +: 8] = dat_i[8*b +: 8];
                end
            end
            bsel_d[tidx] = bsel_q[tidx] | bsel_i;
            pc_d[tidx]   = pc_i;
        end

        // Push after pop: when full with a read, the freed head slot is widx.
        if (push) begin
            valid_d[widx]  = 1'b1;
            atomic_d[widx] = atomic_i;
            pc_d[widx]     = pc_i;
            adr_d[widx]    = adr_i;
            dat_d[widx]    = dat_i;
            bsel_d[widx]   = bsel_i;
            wptr_d         = wptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            valid_q  <= '0;
            atomic_q <= '0;
            pc_q     <= '{default: '0};
            adr_q    <= '{default: '0};
            dat_q    <= '{default: '0};
            bsel_q   <= '{default: '0};
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            valid_q  <= valid_d;
            atomic_q <= atomic_d;
            pc_q     <= pc_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            bsel_q   <= bsel_d;
        end
    end

    assign pc_o     = pc_q[ridx];
    assign adr_o    = adr_q[ridx];
    assign dat_o    = dat_q[ridx];
    assign bsel_o   = bsel_q[ridx];
    assign atomic_o = atomic_q[ridx];
    assign full_o   = full;
    assign empty_o  = empty;
    assign count_o  = count;

    logic [DEPTH-1:0]       match;
    logic                   any_match;
    logic [DEPTH_WIDTH-1:0] y_idx;
    logic [DEPTH_WIDTH-1:0] lk_idx;
    logic                   hit;
    logic                   unused_lookup_lsb;

    assign unused_lookup_lsb = ^lookup_adr_i[1:0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign match[i] = valid_q[i]
                          && (adr_q[i][OW-1:2] == lookup_adr_i[OW-1:2])
                          && |(bsel_q[i] & lookup_bsel_i);
    end

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        any_match = 1'b0;
        y_idx     = ridx;
        lk_idx    = ridx;
        for (int k = 0; k < DEPTH; k++) begin
            lk_idx = ridx + DEPTH_WIDTH'(k);
            if (match[lk_idx]) begin
                any_match = 1'b1;
                y_idx     = lk_idx;
            end
        end
    end

    assign hit = any_match && !atomic_q[y_idx]
                 && ((bsel_q[y_idx] & lookup_bsel_i) == lookup_bsel_i);

    assign lookup_hit_o      = hit;
    assign lookup_dat_o      = hit ? dat_q[y_idx] : '0;
    assign lookup_conflict_o = any_match && !hit;

endmodule

// File: tb/tb_pu_or1k_store_buffer_fwd.sv
// Bench for the forwarding store buffer: directed scenarios plus a randomized
// run scored against a queue-based model of the buffer contents.
module tb_pu_or1k_store_buffer_fwd;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i, adr_i, dat_i;
    logic [3:0]  bsel_i;
    logic        atomic_i, write_i, read_i;
    logic [31:0] pc_o, adr_o, dat_o;
    logic [3:0]  bsel_o;
    logic        atomic_o, full_o, empty_o;
    logic [4:0]  count_o;
    logic [31:0] lookup_adr_i;
    logic [3:0]  lookup_bsel_i;
    logic        lookup_hit_o;
    logic [31:0] lookup_dat_o;
    logic        lookup_conflict_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    pu_or1k_store_buffer_fwd #(
        .DEPTH_WIDTH(4), .OPTION_OPERAND_WIDTH(32), .ENABLE_COALESCE(1)
    ) dut (
        .clk(clk), .rst(rst),
        .pc_i(pc_i), .adr_i(adr_i), .dat_i(dat_i), .bsel_i(bsel_i),
        .atomic_i(atomic_i), .write_i(write_i),
        .pc_o(pc_o), .adr_o(adr_o), .dat_o(dat_o), .bsel_o(bsel_o),
        .atomic_o(atomic_o), .read_i(read_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
        .lookup_adr_i(lookup_adr_i), .lookup_bsel_i(lookup_bsel_i),
        .lookup_hit_o(lookup_hit_o), .lookup_dat_o(lookup_dat_o),
        .lookup_conflict_o(lookup_conflict_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  bsel;
        logic        atomic;
    } ent_t;

    ent_t mq[$];

    // Reference: the buffer is an ordered list of stores, oldest first.
    task automatic step(input logic w, input logic r, input logic [31:0] pc,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] bsel, input logic at);
        int   n;
        logic merge;
        ent_t t;
        write_i = w; read_i = r; pc_i = pc; adr_i = adr; dat_i = dat;
        bsel_i = bsel; atomic_i = at;
        @(posedge clk);
        n = mq.size();
        merge = 1'b0;
        if (w && !at && n > 0) begin
            if (!mq[n-1].atomic && mq[n-1].adr[31:2] == adr[31:2] && !(n == 1 && r))
                merge = 1'b1;
        end
        if (merge) begin
            t = mq[n-1];
            for (int b = 0; b < 4; b++)
                if (bsel[b]) t.dat[8*b +: 8] = dat[8*b +: 8];
            t.bsel = t.bsel | bsel;
            t.pc   = pc;
            mq[n-1] = t;
        end
        if (r && n > 0) void'(mq.pop_front());
        if (w && !merge && (n < 16 || r)) begin
            t.pc = pc; t.adr = adr; t.dat = dat; t.bsel = bsel; t.atomic = at;
            mq.push_back(t);
        end
        #1;
        write_i = 1'b0; read_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        write_i = 1'b0; read_i = 1'b0; atomic_i = 1'b0;
        pc_i = '0; adr_i = '0; dat_i = '0; bsel_i = '0;
        @(posedge clk); @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h10, 32'h80, 32'h1234, 4'hf, 1'b0);
        step(1'b1, 1'b0, 32'h14, 32'h90, 32'h5678, 4'hf, 1'b0);
        do_reset();
        lookup_adr_i = 32'h80; lookup_bsel_i = 4'hf;
        #1;
        total_cnt++;
        if ({empty_o, full_o, count_o} !== {1'b1, 1'b0, 5'd0})
            $display("FAIL reset_status empty/full/count got %b/%b/%0d want 1/0/0", empty_o, full_o, count_o);
        else pass_cnt++;
        total_cnt++;
        if ({pc_o, adr_o, dat_o, bsel_o, atomic_o} !== '0)
            $display("FAIL reset_head got pc=%h adr=%h dat=%h bsel=%b at=%b want all 0", pc_o, adr_o, dat_o, bsel_o, atomic_o);
        else pass_cnt++;
        total_cnt++;
        if ({lookup_hit_o, lookup_conflict_o} !== 2'b00)
            $display("FAIL reset_lookup hit/conflict got %b%b want 00", lookup_hit_o, lookup_conflict_o);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, 32'h1000 + 32'(i), 32'(i * 4), 32'hA000 + 32'(i), 4'hf, 1'b0);
        total_cnt++;
        if ({full_o, count_o} !== {1'b1, 5'd16})
            $display("FAIL fill_full full/count got %b/%0d want 1/16", full_o, count_o);
        else pass_cnt++;
        step(1'b1, 1'b0, 32'h2000, 32'h40, 32'hDEAD, 4'hf, 1'b0);
        total_cnt++;
        if ({full_o, count_o, adr_o} !== {1'b1, 5'd16, 32'h0})
            $display("FAIL fill_drop full/count/head got %b/%0d/%h want 1/16/0", full_o, count_o, adr_o);
        else pass_cnt++;
    endtask

    task automatic test_drain();
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (adr_o !== 32'(i * 4) || dat_o !== 32'hA000 + 32'(i)) begin
                $display("FAIL drain_order pop %0d got adr=%h dat=%h want adr=%h", i, adr_o, dat_o, i * 4);
                bad++;
            end
            step(1'b0, 1'b1, '0, '0, '0, 4'h0, 1'b0);
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
        total_cnt++;
        if ({empty_o, count_o} !== {1'b1, 5'd0})
            $display("FAIL drain_empty empty/count got %b/%0d want 1/0", empty_o, count_o);
        else pass_cnt++;
        step(1'b1, 1'b0, 32'h77, 32'h300, 32'hFACE, 4'hf, 1'b0);
        total_cnt++;
        if ({empty_o, count_o, adr_o, dat_o} !== {1'b0, 5'd1, 32'h300, 32'hFACE})
            $display("FAIL wrap_push empty/count/adr/dat got %b/%0d/%h/%h want 0/1/300/face", empty_o, count_o, adr_o, dat_o);
        else pass_cnt++;
        step(1'b0, 1'b1, '0, '0, '0, 4'h0, 1'b0);
        step(1'b0, 1'b1, '0, '0, '0, 4'h0, 1'b0);
        total_cnt++;
        if ({empty_o, count_o} !== {1'b1, 5'd0})
            $display("FAIL wrap_pop empty/count got %b/%0d want 1/0", empty_o, count_o);
        else pass_cnt++;
    endtask

    task automatic test_coalesce();
        do_reset();
        step(1'b1, 1'b0, 32'h1, 32'h100, 32'h0000BEEF, 4'b0011, 1'b0);
        step(1'b1, 1'b0, 32'h2, 32'h102, 32'hCAFE0000, 4'b1100, 1'b0);
        total_cnt++;
        if ({count_o, bsel_o, dat_o, pc_o} !== {5'd1, 4'b1111, 32'hCAFEBEEF, 32'h2})
            $display("FAIL coalesce count/bsel/dat/pc got %0d/%b/%h/%h want 1/1111/cafebeef/2", count_o, bsel_o, dat_o, pc_o);
        else pass_cnt++;
    endtask

    task automatic test_atomic();
        do_reset();
        step(1'b1, 1'b0, 32'h1, 32'h100, 32'h0000BEEF, 4'b0011, 1'b0);
        step(1'b1, 1'b0, 32'h2, 32'h102, 32'hCAFE0000, 4'b1100, 1'b1);
        total_cnt++;
        if ({count_o, bsel_o, dat_o, atomic_o} !== {5'd2, 4'b0011, 32'h0000BEEF, 1'b0})
            $display("FAIL atomic_nomerge count/bsel/dat/at got %0d/%b/%h/%b want 2/0011/0000beef/0", count_o, bsel_o, dat_o, atomic_o);
        else pass_cnt++;
        lookup_adr_i = 32'h100; lookup_bsel_i = 4'b0100;
        #1;
        total_cnt++;
        if ({lookup_hit_o, lookup_conflict_o} !== 2'b01)
            $display("FAIL atomic_lookup hit/conflict got %b%b want 01", lookup_hit_o, lookup_conflict_o);
        else pass_cnt++;
    endtask

    task automatic test_lookup();
        do_reset();
        step(1'b1, 1'b0, 32'h5, 32'h200, 32'h11223344, 4'b1111, 1'b0);
        lookup_adr_i = 32'h200; lookup_bsel_i = 4'b0001;
        #1;
        total_cnt++;
        if ({lookup_hit_o, lookup_conflict_o, lookup_dat_o} !== {2'b10, 32'h11223344})
            $display("FAIL lookup_hit hit/conflict/dat got %b%b/%h want 10/11223344", lookup_hit_o, lookup_conflict_o, lookup_dat_o);
        else pass_cnt++;
        lookup_adr_i = 32'h204; lookup_bsel_i = 4'b1111;
        #1;
        total_cnt++;
        if ({lookup_hit_o, lookup_conflict_o, lookup_dat_o} !== {2'b00, 32'h0})
            $display("FAIL lookup_miss hit/conflict/dat got %b%b/%h want 00/0", lookup_hit_o, lookup_conflict_o, lookup_dat_o);
        else pass_cnt++;
        do_reset();
        step(1'b1, 1'b0, 32'h6, 32'h200, 32'h00003344, 4'b0011, 1'b0);
        lookup_adr_i = 32'h200; lookup_bsel_i = 4'b1111;
        #1;
        total_cnt++;
        if ({lookup_hit_o, lookup_conflict_o, lookup_dat_o} !== {2'b01, 32'h0})
            $display("FAIL lookup_partial hit/conflict/dat got %b%b/%h want 01/0", lookup_hit_o, lookup_conflict_o, lookup_dat_o);
        else pass_cnt++;
    endtask

    task automatic test_pop_push_tail();
        do_reset();
        step(1'b1, 1'b0, 32'h8, 32'h400, 32'h00000001, 4'b1111, 1'b0);
        step(1'b1, 1'b1, 32'h9, 32'h400, 32'h00000002, 4'b1111, 1'b0);
        total_cnt++;
        if ({count_o, dat_o, pc_o} !== {5'd1, 32'h2, 32'h9})
            $display("FAIL pop_push_tail count/dat/pc got %0d/%h/%h want 1/2/9", count_o, dat_o, pc_o);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int   bad = 0;
        int   y;
        logic exp_hit, exp_conf;
        logic [31:0] exp_dat;
        logic w, r, at;
        logic [31:0] adr;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            lookup_adr_i  = {26'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
            lookup_bsel_i = 4'($urandom_range(1, 15));
            #1;
            y = -1;
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (y < 0 && mq[i].adr[31:2] == lookup_adr_i[31:2] && (mq[i].bsel & lookup_bsel_i) != 0)
                    y = i;
            end
            exp_hit  = (y >= 0) && !mq[y].atomic && ((mq[y].bsel & lookup_bsel_i) == lookup_bsel_i);
            exp_conf = (y >= 0) && !exp_hit;
            exp_dat  = exp_hit ? mq[y].dat : 32'h0;
            if ({lookup_hit_o, lookup_conflict_o, lookup_dat_o} !== {exp_hit, exp_conf, exp_dat}) begin
                $display("FAIL rand_lookup cyc %0d got %b%b/%h want %b%b/%h", c, lookup_hit_o, lookup_conflict_o, lookup_dat_o, exp_hit, exp_conf, exp_dat);
                bad++;
            end
            if (count_o !== 5'(mq.size()) || empty_o !== (mq.size() == 0) || full_o !== (mq.size() == 16)) begin
                $display("FAIL rand_status cyc %0d got cnt=%0d e=%b f=%b want cnt=%0d", c, count_o, empty_o, full_o, mq.size());
                bad++;
            end
            if (mq.size() > 0) begin
                if ({pc_o, adr_o, dat_o, bsel_o, atomic_o} !== {mq[0].pc, mq[0].adr, mq[0].dat, mq[0].bsel, mq[0].atomic}) begin
                    $display("FAIL rand_head cyc %0d got adr=%h dat=%h bsel=%b want adr=%h dat=%h bsel=%b", c, adr_o, dat_o, bsel_o, mq[0].adr, mq[0].dat, mq[0].bsel);
                    bad++;
                end
            end
            w   = ($urandom_range(0, 99) < 60);
            r   = ($urandom_range(0, 99) < (c < 200 ? 35 : 55));
            at  = ($urandom_range(0, 99) < 10);
            adr = {26'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
            if (mq.size() == 16 && !r) w = 1'b0;
            step(w, r, $urandom, adr, $urandom, 4'($urandom_range(1, 15)), at);
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        write_i = 1'b0; read_i = 1'b0; atomic_i = 1'b0;
        pc_i = '0; adr_i = '0; dat_i = '0; bsel_i = '0;
        lookup_adr_i = '0; lookup_bsel_i = '0;
        do_reset();
        test_reset();
        test_fill();
        test_drain();
        test_coalesce();
        test_atomic();
        test_lookup();
        test_pop_push_tail();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
